// File: rtl/uart_tx.sv
// UART transmitter: accepts one word over a ready/valid handshake and serialises it as
// start bit, data LSB first, optional even parity, then one or two stop bits.
module uart_tx #(
  parameter int unsigned clk_per_bit_p = 10416,
  parameter int unsigned data_bits_p   = 8,
  parameter int unsigned parity_bit_p  = 0,
  parameter int unsigned stop_bits_p   = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [data_bits_p-1:0] tx_i,
  input  logic                   tx_v_i,
  output logic                   tx_ready_and_o,
  output logic                   tx_o,
  output logic                   tx_done_o
);

  localparam int unsigned BaudW = $clog2(clk_per_bit_p);
  localparam int unsigned BitW  = $clog2(data_bits_p + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(clk_per_bit_p - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(data_bits_p - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(stop_bits_p - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q, state_d;
  logic [BaudW-1:0]       baud_q, baud_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [data_bits_p-1:0] shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  logic                   baud_end;

  assign baud_end = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    if (state_q != StIdle) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        // Ready is asserted whenever we are idle and out of reset, so valid alone is the handshake.
        if (tx_v_i) begin
          shift_d  = tx_i;
          parity_d = ^tx_i;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_end) state_d = StData;
      end
      StData: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = (parity_bit_p != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (baud_end) state_d = StStop;
      end
      StStop: begin
        if (baud_end) begin
          if (bit_q == StopLast) begin
            bit_d   = '0;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is registered from next-state so tx_o never glitches.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  assign tx_o           = tx_q;
  assign tx_ready_and_o = reset_n_i & (state_q == StIdle);
  assign tx_done_o      = (state_q == StStop) & baud_end & (bit_q == StopLast);

  assert property (@(posedge clk_i)
    (clk_per_bit_p >= 2) && (data_bits_p >= 5) && (data_bits_p <= 9) &&
    (parity_bit_p <= 1) && (stop_bits_p >= 1) && (stop_bits_p <= 2));

  assert property (@(posedge clk_i) reset_n_i |-> !$isunknown(tx_v_i));

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (8N1, 8E1, 5N2) at 4 clocks per bit; stimulus
// pushes hand-computed line patterns, per-instance monitors decode frames and compare.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] v;
  logic [2:0] rdy;
  logic [2:0] line;
  logic [2:0] done;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  int         cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] bits;
    int          n;
    int          hs;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.clk_per_bit_p(4), .data_bits_p(8), .parity_bit_p(0), .stop_bits_p(1)) u_8n1 (
    .clk_i(clk), .reset_n_i(rst_n[0]), .tx_i(d0), .tx_v_i(v[0]),
    .tx_ready_and_o(rdy[0]), .tx_o(line[0]), .tx_done_o(done[0])
  );

  uart_tx #(.clk_per_bit_p(4), .data_bits_p(8), .parity_bit_p(1), .stop_bits_p(1)) u_8e1 (
    .clk_i(clk), .reset_n_i(rst_n[1]), .tx_i(d1), .tx_v_i(v[1]),
    .tx_ready_and_o(rdy[1]), .tx_o(line[1]), .tx_done_o(done[1])
  );

  uart_tx #(.clk_per_bit_p(4), .data_bits_p(5), .parity_bit_p(0), .stop_bits_p(2)) u_5n2 (
    .clk_i(clk), .reset_n_i(rst_n[2]), .tx_i(d2), .tx_v_i(v[2]),
    .tx_ready_and_o(rdy[2]), .tx_o(line[2]), .tx_done_o(done[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decodes one frame per start bit; expects the line flat for each 4-cycle bit, done only on
  // the final cycle, ready low throughout, then one idle-high ready cycle.
  task automatic monitor(input int k, input int n);
    logic [15:0] got;
    int          s, glitch, derr, rerr, has;
    bit          aborted;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_n[k] !== 1'b1 || line[k] !== 1'b0) continue;
      s = cyc; got = '0; glitch = 0; derr = 0; rerr = 0; aborted = 0;
      for (int c = 0; c < n * 4; c++) begin
        if (c > 0) @(negedge clk);
        if (rst_n[k] !== 1'b1) begin
          aborted = 1;
          break;
        end
        if (c % 4 == 0) got[c/4] = line[k];
        else if (line[k] !== got[c/4]) glitch++;
        if (done[k] !== (c == n * 4 - 1)) derr++;
        if (rdy[k] !== 1'b0) rerr++;
      end
      if (aborted) continue;
      @(negedge clk);
      has = 0;
      if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); has = 1; end
      if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); has = 1; end
      if (k == 2 && q2.size() > 0) begin e = q2.pop_front(); has = 1; end
      check($sformatf("inst%0d frame_expected", k), has, 1);
      if (has != 0) begin
        check($sformatf("inst%0d frame_bits", k), got, e.bits);
        check($sformatf("inst%0d start_cycle", k), s, e.hs + 1);
      end
      check($sformatf("inst%0d bit_glitches", k), glitch, 0);
      check($sformatf("inst%0d done_timing_errs", k), derr, 0);
      check($sformatf("inst%0d ready_in_frame_errs", k), rerr, 0);
      check($sformatf("inst%0d idle_after {rdy,tx,done}", k), {rdy[k], line[k], done[k]}, 3'b110);
    end
  endtask

  task automatic send(input int k, input logic [7:0] data, input logic [15:0] frame, input int n,
                      input bit push, input bit keep, output int hs);
    if (k == 0) d0 = data;
    if (k == 1) d1 = data;
    if (k == 2) d2 = data[4:0];
    v[k] = 1'b1;
    hs = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[k] === 1'b1) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL inst%0d handshake_timeout: got no ready, expected ready within 200 cycles", k);
    end else if (push) begin
      if (k == 0) q0.push_back('{frame, n, hs});
      if (k == 1) q1.push_back('{frame, n, hs});
      if (k == 2) q2.push_back('{frame, n, hs});
    end
    @(posedge clk);
    #1;
    if (!keep) v[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h1, h2, h3, dsum;
    rst_n = 3'b000;
    v     = 3'b000;
    d0    = '0;
    d1    = '0;
    d2    = '0;
    fork
      monitor(0, 10);
      monitor(1, 11);
      monitor(2, 8);
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset tx", line, 3'b111);
    check("reset ready", rdy, 3'b000);
    check("reset done", done, 3'b000);
    rst_n = 3'b111;
    #1;
    check("ready after release", rdy, 3'b111);

    // Frame bit i is the i-th bit on the line.
    send(0, 8'hA5, 16'h034A, 10, 1, 0, h);  // 0,1,0,1,0,0,1,0,1,1
    send(1, 8'h07, 16'h060E, 11, 1, 0, h);  // 0,1,1,1,0,0,0,0,0,1(par),1
    send(1, 8'h03, 16'h0406, 11, 1, 0, h);  // 0,1,1,0,0,0,0,0,0,0(par),1
    send(2, 8'h1F, 16'h00FE, 8, 1, 0, h);   // 0,1,1,1,1,1,1,1

    // Valid held across three words; data changes while busy must be ignored.
    send(0, 8'h00, 16'h0200, 10, 1, 1, h1);
    send(0, 8'hFF, 16'h03FE, 10, 1, 1, h2);
    send(0, 8'h55, 16'h02AA, 10, 1, 0, h3);
    check("b2b spacing 1-2", h2 - h1, 41);
    check("b2b spacing 2-3", h3 - h2, 41);

    // Reset in the middle of the data bits of 0xA5: frame abandoned, no done pulse.
    send(0, 8'hA5, 16'h0000, 10, 0, 0, h);
    repeat (8) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    check("mid-reset ready forced low", rdy[0], 1'b0);
    dsum = done[0];
    @(posedge clk);
    #1;
    check("mid-reset tx after edge", line[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dsum += done[0];
    end
    check("mid-reset done pulses", dsum, 0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    #1;
    check("mid-reset ready after release", rdy[0], 1'b1);
    send(0, 8'h3C, 16'h0278, 10, 1, 0, h);  // 0,0,0,1,1,1,1,0,0,1

    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("inst0 frames outstanding", q0.size(), 0);
    check("inst1 frames outstanding", q1.size(), 0);
    check("inst2 frames outstanding", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
